ext_stream_sequencer: RTL and testbench

- Host-side transmitter for the matrix-mult external-mode interface.
- Preloads one weight tile and up to DEPTH input/psum vectors from a host write port.
- On start, drives the external-inputs bundle: ROW weight beats, then N input beats. It then collects N result beats into a readable result buffer and signals done.
- Sits between the test host/scan logic and the wrapper's external inputs and outputs.

---
 rtl/ext_stream_sequencer_pkg.sv | 27 ++
 rtl/ext_seq_result_buf.sv | 60 ++++++
 rtl/ext_stream_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ext_stream_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_stream_sequencer_pkg.sv
// Shared types for the external-mode stream sequencer: drive bundle, FSM states, error bit indices.
package ext_stream_sequencer_pkg;

  localparam int unsigned EXT_WIDTH = 8;
  localparam int unsigned EXT_ROW   = 4;
  localparam int unsigned EXT_COL   = 4;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_TMO = 1;

  typedef struct packed {
    logic                           ext_weight_en;
    logic [EXT_ROW*EXT_WIDTH-1:0]   ext_input;
    logic                           ext_valid;
    logic [EXT_COL*EXT_WIDTH-1:0]   ext_weight;
    logic [EXT_COL*EXT_WIDTH-1:0]   ext_psum;
  } external_inputs_struct;

  typedef enum logic [2:0] {
    StIdle,
    StWload,
    StStream,
    StCollect,
    StDone
  } seq_state_e;

endpackage

// File: rtl/ext_seq_result_buf.sv
// Circular result buffer: write port, registered read port, wrap-around pointers and fill count.
module ext_seq_result_buf #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            wr_en_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            rd_en_i,
  output logic [DW-1:0]   rd_data_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    do_rd = rd_en_i & (count_o != '0) & ~clr_i;
  end

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_o   <= '0;
      rd_data_o <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o  <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_rd) begin
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
        rd_data_o <= mem_q[rd_ptr_q];
      end
      count_o <= count_o + CntW'(wr_en_i) - CntW'(do_rd);
    end
  end

endmodule

// File: rtl/ext_stream_sequencer.sv
// Host-side transmitter for the array external mode: streams a weight tile and N vectors, collects
// N results. Optional COLLECT idle timeout enabled by defining EXT_SEQ_TIMEOUT_EN.
module ext_stream_sequencer
  import ext_stream_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = EXT_WIDTH,
  parameter int unsigned ROW          = EXT_ROW,
  parameter int unsigned COL          = EXT_COL,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned DRIVER_WIDTH = WIDTH * (ROW + COL)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [$clog2(DEPTH+1)-1:0]    num_vec_i,
  input  logic                          wgt_wr_en_i,
  input  logic [$clog2(ROW)-1:0]        wgt_wr_addr_i,
  input  logic [COL*WIDTH-1:0]          wgt_wr_data_i,
  input  logic                          vec_wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]      vec_wr_addr_i,
  input  logic [(ROW+COL)*WIDTH-1:0]    vec_wr_data_i,
  output logic                          ext_en_o,
  output external_inputs_struct         ext_inputs_o,
  input  logic [DRIVER_WIDTH-1:0]       ext_result_i,
  input  logic                          ext_valid_i,
  input  logic                          res_rd_en_i,
  output logic [COL*WIDTH-1:0]          res_rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]    res_count_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [1:0]                    err_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RowW = $clog2(ROW);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned VecW = (ROW + COL) * WIDTH;
  localparam int unsigned ResW = COL * WIDTH;

  seq_state_e     state_q;
  logic           start_q;
  logic [CntW-1:0] n_q, cap_cnt_q, cap_cnt_d, n_clamped;
  logic [AW-1:0]   vec_idx_q;
  logic [RowW-1:0] row_q;
  logic [ResW-1:0] wgt_q [ROW];
  logic [VecW-1:0] vec_q [DEPTH];
  logic            start_acc, run_active, cap_fire, discard, clamp;

  always_comb begin
    start_acc  = start_i & ~start_q & ((state_q == StIdle) || (state_q == StDone));
    run_active = (state_q == StStream) || (state_q == StCollect);
    cap_fire   = ext_valid_i & run_active & (cap_cnt_q < n_q);
    discard    = ext_valid_i & ~cap_fire;
    cap_cnt_d  = cap_cnt_q + CntW'(cap_fire);
    clamp      = num_vec_i > CntW'(DEPTH);
    n_clamped  = clamp ? CntW'(DEPTH) : num_vec_i;
  end

  // Host writes land only while no run is in progress.
  always_ff @(posedge clk_i) begin
    if (!busy_o && wgt_wr_en_i) begin
      wgt_q[wgt_wr_addr_i] <= wgt_wr_data_i;
    end
    if (!busy_o && vec_wr_en_i) begin
      vec_q[vec_wr_addr_i] <= vec_wr_data_i;
    end
  end

`ifdef EXT_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      n_q          <= '0;
      cap_cnt_q    <= '0;
      vec_idx_q    <= '0;
      row_q        <= '0;
      ext_inputs_o <= '0;
      ext_en_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= '0;
`ifdef EXT_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      start_q      <= start_i;
      cap_cnt_q    <= cap_cnt_d;
      ext_inputs_o <= '0;
      if (discard) begin
        err_o[ERR_OVF] <= 1'b1;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start_acc) begin
            state_q                    <= StWload;
            n_q                        <= n_clamped;
            cap_cnt_q                  <= '0;
            row_q                      <= '0;
            err_o[ERR_OVF]             <= clamp | discard;
            err_o[ERR_TMO]             <= 1'b0;
            busy_o                     <= 1'b1;
            ext_en_o                   <= 1'b1;
            done_o                     <= 1'b0;
            ext_inputs_o.ext_weight_en <= 1'b1;
            ext_inputs_o.ext_weight    <= wgt_q[0];
          end
        end
        StWload: begin
          if (row_q == RowW'(ROW - 1)) begin
            if (n_q == '0) begin
              // Nothing to stream or collect: finish straight away.
              state_q  <= StDone;
              busy_o   <= 1'b0;
              ext_en_o <= 1'b0;
              done_o   <= 1'b1;
            end else begin
              state_q                <= StStream;
              vec_idx_q              <= '0;
              ext_inputs_o.ext_valid <= 1'b1;
              {ext_inputs_o.ext_input, ext_inputs_o.ext_psum} <= vec_q[0];
            end
          end else begin
            row_q                      <= row_q + RowW'(1);
            ext_inputs_o.ext_weight_en <= 1'b1;
            ext_inputs_o.ext_weight    <= wgt_q[row_q + RowW'(1)];
          end
        end
        StStream: begin
          if (CntW'(vec_idx_q) == n_q - CntW'(1)) begin
            state_q <= StCollect;
`ifdef EXT_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else begin
            vec_idx_q              <= vec_idx_q + AW'(1);
            ext_inputs_o.ext_valid <= 1'b1;
            {ext_inputs_o.ext_input, ext_inputs_o.ext_psum} <= vec_q[vec_idx_q + AW'(1)];
          end
        end
        StCollect: begin
          if (cap_cnt_d == n_q) begin
            state_q  <= StDone;
            busy_o   <= 1'b0;
            ext_en_o <= 1'b0;
            done_o   <= 1'b1;
`ifdef EXT_SEQ_TIMEOUT_EN
          end else if (cap_fire) begin
            tmo_q <= '0;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            state_q        <= StDone;
            busy_o         <= 1'b0;
            ext_en_o       <= 1'b0;
            done_o         <= 1'b1;
            err_o[ERR_TMO] <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the low COL lanes of the wrapper result carry data.
  logic unused_result_hi;
  assign unused_result_hi = ^ext_result_i[DRIVER_WIDTH-1:ResW];

  ext_seq_result_buf #(
    .DW   (ResW),
    .DEPTH(DEPTH)
  ) u_res_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (start_acc),
    .wr_en_i  (cap_fire),
    .wr_data_i(ext_result_i[ResW-1:0]),
    .rd_en_i  (res_rd_en_i),
    .rd_data_o(res_rd_data_o),
    .count_o  (res_count_o)
  );

endmodule

// File: tb/tb_ext_stream_sequencer.sv
// Self-checking bench for ext_stream_sequencer: table runs, random runs, and corner sequences.
module tb_ext_stream_sequencer;
  import ext_stream_sequencer_pkg::*;

  localparam int WIDTH = 8, ROW = 4, COL = 4, DEPTH = 16, TIMEOUT = 8;
  localparam int DW = WIDTH * (ROW + COL), CW = COL * WIDTH, VW = (ROW + COL) * WIDTH;
  localparam int CNTW = $clog2(DEPTH + 1), AW = $clog2(DEPTH), RW = $clog2(ROW);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [CNTW-1:0] num_vec_i = '0;
  logic wgt_wr_en_i = 1'b0;
  logic [RW-1:0] wgt_wr_addr_i = '0;
  logic [CW-1:0] wgt_wr_data_i = '0;
  logic vec_wr_en_i = 1'b0;
  logic [AW-1:0] vec_wr_addr_i = '0;
  logic [VW-1:0] vec_wr_data_i = '0;
  logic ext_en_o;
  external_inputs_struct ext_inputs_o;
  logic [DW-1:0] ext_result_i = '0;
  logic ext_valid_i = 1'b0;
  logic res_rd_en_i = 1'b0;
  logic [CW-1:0] res_rd_data_o;
  logic [CNTW-1:0] res_count_o;
  logic busy_o, done_o;
  logic [1:0] err_o;

  ext_stream_sequencer #(
    .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DRIVER_WIDTH(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_vec_i(num_vec_i),
    .wgt_wr_en_i(wgt_wr_en_i), .wgt_wr_addr_i(wgt_wr_addr_i), .wgt_wr_data_i(wgt_wr_data_i),
    .vec_wr_en_i(vec_wr_en_i), .vec_wr_addr_i(vec_wr_addr_i), .vec_wr_data_i(vec_wr_data_i),
    .ext_en_o(ext_en_o), .ext_inputs_o(ext_inputs_o), .ext_result_i(ext_result_i),
    .ext_valid_i(ext_valid_i), .res_rd_en_i(res_rd_en_i), .res_rd_data_o(res_rd_data_o),
    .res_count_o(res_count_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] wgt_m [ROW];
  logic [VW-1:0] vec_m [DEPTH];
  logic [CW-1:0] last_rd = '0;

  typedef struct {
    int n_in;
    int delay;
    int exp_n;
    int exp_done;
    logic [1:0] exp_err;
    bit extra;
    logic [1:0] err_after;
  } run_vec_t;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected drive bundle at sample index i after the start edge.
  function automatic logic [255:0] exp_trace(int i, int n, int done_i);
    external_inputs_struct e;
    logic en, busy, dn;
    e = '0;
    if (i >= done_i) begin
      {en, busy, dn} = 3'b001;
    end else begin
      {en, busy, dn} = 3'b110;
      if (i < ROW) begin
        e.ext_weight_en = 1'b1;
        e.ext_weight    = wgt_m[i];
      end else if (i < ROW + n) begin
        e.ext_valid = 1'b1;
        {e.ext_input, e.ext_psum} = vec_m[i-ROW];
      end
    end
    return 256'({en, busy, dn, e});
  endfunction

  task automatic load_random();
    for (int r = 0; r < ROW; r++) begin
      wgt_m[r] = $urandom;
      wgt_wr_en_i = 1'b1; wgt_wr_addr_i = RW'(r); wgt_wr_data_i = wgt_m[r];
      step();
    end
    wgt_wr_en_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      vec_m[k] = {$urandom, $urandom};
      vec_wr_en_i = 1'b1; vec_wr_addr_i = AW'(k); vec_wr_data_i = vec_m[k];
      step();
    end
    vec_wr_en_i = 1'b0;
  endtask

  task automatic run_check(input run_vec_t v);
    int due_q[$];
    logic [DW-1:0] val_q[$];
    logic [CW-1:0] res_q[$];
    logic [DW-1:0] r;
    load_random();
    num_vec_i = CNTW'(v.n_in);
    start_i = 1'b1;
    step();
    for (int i = 0; i <= v.exp_done; i++) begin
      check($sformatf("trace[n=%0d,i=%0d]", v.n_in, i),
            256'({ext_en_o, busy_o, done_o, ext_inputs_o}), exp_trace(i, v.exp_n, v.exp_done));
      if (i >= ROW && i < ROW + v.exp_n) begin
        r = {$urandom, $urandom};
        due_q.push_back(i + v.delay);
        val_q.push_back(r);
        res_q.push_back(r[CW-1:0]);
      end
      ext_valid_i = 1'b0;
      ext_result_i = {$urandom, $urandom};
      if (due_q.size() > 0 && due_q[0] == i) begin
        void'(due_q.pop_front());
        ext_valid_i = 1'b1;
        ext_result_i = val_q.pop_front();
      end
      // Writes and a start edge while busy must have no effect.
      wgt_wr_en_i = (i == 1); wgt_wr_addr_i = '0; wgt_wr_data_i = $urandom;
      vec_wr_en_i = (i == 1); vec_wr_addr_i = '0; vec_wr_data_i = {$urandom, $urandom};
      start_i = (i == 2);
      if (i < v.exp_done) step();
    end
    ext_valid_i = 1'b0; wgt_wr_en_i = 1'b0; vec_wr_en_i = 1'b0; start_i = 1'b0;
    check("count_at_done", 256'(res_count_o), 256'(v.exp_n));
    check("err_at_done", 256'(err_o), 256'(v.exp_err));
    if (v.extra) begin
      ext_valid_i = 1'b1;
      ext_result_i = {$urandom, $urandom};
      step();
      ext_valid_i = 1'b0;
      check("extra_pulse_count", 256'(res_count_o), 256'(v.exp_n));
      check("extra_pulse_err", 256'(err_o), 256'(v.err_after));
    end
    for (int k = 0; k < v.exp_n; k++) begin
      res_rd_en_i = 1'b1;
      step();
      res_rd_en_i = 1'b0;
      last_rd = res_q[k];
      check($sformatf("pop_data[%0d]", k), 256'(res_rd_data_o), 256'(last_rd));
      check($sformatf("pop_count[%0d]", k), 256'(res_count_o), 256'(v.exp_n - 1 - k));
    end
    res_rd_en_i = 1'b1;
    step();
    res_rd_en_i = 1'b0;
    check("empty_pop_data", 256'(res_rd_data_o), 256'(last_rd));
    check("empty_pop_count", 256'(res_count_o), 256'(0));
  endtask

  run_vec_t tbl[5];
  run_vec_t rv;
  logic [DW-1:0] ra;

  initial begin
    tbl[0] = '{n_in: 3,  delay: 5, exp_n: 3,  exp_done: 12, exp_err: 2'b00, extra: 0,
               err_after: 2'b00};
    tbl[1] = '{n_in: 0,  delay: 5, exp_n: 0,  exp_done: 4,  exp_err: 2'b00, extra: 0,
               err_after: 2'b00};
    tbl[2] = '{n_in: 20, delay: 2, exp_n: 16, exp_done: 22, exp_err: 2'b01, extra: 1,
               err_after: 2'b01};
    tbl[3] = '{n_in: 1,  delay: 1, exp_n: 1,  exp_done: 6,  exp_err: 2'b00, extra: 1,
               err_after: 2'b01};
    tbl[4] = '{n_in: 16, delay: 3, exp_n: 16, exp_done: 23, exp_err: 2'b00, extra: 0,
               err_after: 2'b00};

    repeat (3) step();
    rst_i = 1'b0;
    check("reset_outputs",
          256'({ext_en_o, ext_inputs_o, busy_o, done_o, err_o, res_rd_data_o, res_count_o}),
          256'(0));
    step();
    check("idle_outputs",
          256'({ext_en_o, ext_inputs_o, busy_o, done_o, err_o, res_rd_data_o, res_count_o}),
          256'(0));

    for (int t = 0; t < 5; t++) run_check(tbl[t]);

    for (int t = 0; t < 8; t++) begin
      rv.n_in      = $urandom_range(0, 20);
      rv.delay     = $urandom_range(1, 6);
      rv.exp_n     = (rv.n_in > DEPTH) ? DEPTH : rv.n_in;
      rv.exp_done  = (rv.exp_n == 0) ? ROW : ROW + rv.exp_n + rv.delay;
      rv.exp_err   = (rv.n_in > DEPTH) ? 2'b01 : 2'b00;
      rv.extra     = 1'($urandom_range(0, 1));
      rv.err_after = rv.extra ? 2'b01 : rv.exp_err;
      run_check(rv);
    end

    // Reset during the second stream beat, then replay from weight row 0.
    load_random();
    num_vec_i = CNTW'(3);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (ROW + 1) step();
    check("mid_run_beat", 256'(ext_inputs_o.ext_valid), 256'(1));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    last_rd = '0;
    check("mid_run_reset",
          256'({ext_en_o, ext_inputs_o, busy_o, done_o, err_o, res_rd_data_o, res_count_o}),
          256'(0));
    run_check(tbl[0]);

    // Capture and pop in the same cycle with two results held.
    num_vec_i = CNTW'(3);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (ROW + 3) step();
    ra = {$urandom, $urandom};
    ext_valid_i = 1'b1; ext_result_i = ra;
    step();
    ext_result_i = {$urandom, $urandom};
    step();
    check("pre_overlap_count", 256'(res_count_o), 256'(2));
    ext_result_i = {$urandom, $urandom};
    res_rd_en_i = 1'b1;
    step();
    ext_valid_i = 1'b0;
    res_rd_en_i = 1'b0;
    last_rd = ra[CW-1:0];
    check("overlap_count", 256'(res_count_o), 256'(2));
    check("overlap_data", 256'(res_rd_data_o), 256'(last_rd));
    check("overlap_done", 256'(done_o), 256'(1));

`ifdef EXT_SEQ_TIMEOUT_EN
    // No results returned: DONE TIMEOUT cycles after entering COLLECT.
    num_vec_i = CNTW'(2);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i <= ROW + 2 + TIMEOUT; i++) begin
      if (i == ROW + 2 + TIMEOUT - 1) check("tmo_not_yet", 256'(done_o), 256'(0));
      if (i == ROW + 2 + TIMEOUT) begin
        check("tmo_done", 256'(done_o), 256'(1));
        check("tmo_err", 256'(err_o), 256'(2'b10));
      end
      if (i < ROW + 2 + TIMEOUT) step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
